// File: rtl/rv32_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding, bubble instruction, default reset PC.
package rv32_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;

   // Instruction fetch addresses are always word aligned.
   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble with PC fields held.
module if_id_reg
   import rv32_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        load_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (flush_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!stall_i) begin
         if (load_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
         end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= 32'h0;
         pc_plus4_q <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single outstanding memory request and IF/ID register.
// Optional misaligned-redirect pulse enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_f_i,
   input  logic        stall_d_i,
   input  logic        flush_d_i,
   input  logic        pc_src_e_i,
   input  logic [31:0] pc_target_e_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc_plus4_d_o,
   output logic        valid_d_o,
   output logic        fetch_misalign_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_f_q, pc_f_d;
   logic [31:0]  pc_req_q, pc_req_d;
   logic [31:0]  hold_instr_q, hold_instr_d;
   logic [31:0]  hold_pc_q, hold_pc_d;
   logic         handshake;
   logic         load;
   logic         from_hold;
   logic [31:0]  ifid_instr;
   logic [31:0]  ifid_pc;

   assign imem_req_o  = (state_q == S_REQ) & ~stall_f_i & ~pc_src_e_i;
   assign imem_addr_o = pc_f_q;
   assign handshake   = imem_req_o & imem_gnt_i;

   always_comb begin
      pc_f_d   = pc_f_q;
      pc_req_d = pc_req_q;
      if (pc_src_e_i) begin
         pc_f_d = align_pc(pc_target_e_i);
      end else if (handshake) begin
         pc_f_d = pc_f_q + 32'd4;
      end
      if (handshake) begin
         pc_req_d = pc_f_q;
      end
   end

   // A redirect while a response is still pending must wait for that response in S_DROP.
   always_comb begin
      state_d      = state_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;
      load         = 1'b0;
      from_hold    = 1'b0;
      case (state_q)
         S_REQ: begin
            if (handshake) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (pc_src_e_i) begin
               state_d = imem_rvalid_i ? S_REQ : S_DROP;
            end else if (imem_rvalid_i) begin
               if (stall_d_i) begin
                  hold_instr_d = imem_rdata_i;
                  hold_pc_d    = pc_req_q;
                  state_d      = S_HOLD;
               end else begin
                  load    = 1'b1;
                  state_d = S_REQ;
               end
            end
         end
         S_HOLD: begin
            if (pc_src_e_i) begin
               state_d = S_REQ;
            end else if (!stall_d_i) begin
               load      = 1'b1;
               from_hold = 1'b1;
               state_d   = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid_i) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_REQ;
         pc_f_q       <= RESET_PC;
         pc_req_q     <= RESET_PC;
         hold_instr_q <= 32'h0;
         hold_pc_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_f_q       <= pc_f_d;
         pc_req_q     <= pc_req_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   assign ifid_instr = from_hold ? hold_instr_q : imem_rdata_i;
   assign ifid_pc    = from_hold ? hold_pc_q : pc_req_q;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .flush_i    (flush_d_i),
      .stall_i    (stall_d_i),
      .load_i     (load),
      .instr_i    (ifid_instr),
      .pc_i       (ifid_pc),
      .pc_plus4_i (ifid_pc + 32'd4),
      .instr_o    (instr_d_o),
      .pc_o       (pc_d_o),
      .pc_plus4_o (pc_plus4_d_o),
      .valid_o    (valid_d_o)
   );

`ifdef FETCH_MISALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign misalign_d = pc_src_e_i & (pc_target_e_i[1:0] != 2'b00);

   always_ff @(posedge clk_i) begin
      if (rst_i) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end

   assign fetch_misalign_o = misalign_q;
`else
   assign fetch_misalign_o = 1'b0;
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-003 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 stall_f_i  input  1  hold PC, issue no new request.
REQ-006 stall_d_i  input  1  hold IF/ID register.
REQ-007 flush_d_i  input  1  clear IF/ID register to bubble.
REQ-008 pc_src_e_i  input  1  taken branch/jump redirect from execute.
REQ-009 pc_target_e_i  input  32  redirect target.
REQ-010 imem_req_o  output  1  instruction fetch request.
REQ-011 imem_addr_o  output  32  fetch address, equals pc_f.
REQ-012 imem_gnt_i  input  1  request accepted this cycle.
REQ-013 imem_rvalid_i  input  1  response valid; one response per grant.
REQ-014 imem_rdata_i  input  32  response instruction.
REQ-015 instr_d_o  output  32  IF/ID instruction.
REQ-016 pc_d_o  output  32  IF/ID PC.
REQ-017 pc_plus4_d_o  output  32  IF/ID PC+4.
REQ-018 valid_d_o  output  1  IF/ID holds a real instruction.
REQ-019 fetch_misalign_o  output  1  one-cycle misaligned-target pulse.

Function
REQ-020 At most one outstanding request; FSM states S_REQ, S_WAIT, S_HOLD, S_DROP.
REQ-021 imem_req_o SHALL equal (state==S_REQ) & ~stall_f_i & ~pc_src_e_i, combinationally.
REQ-022 S_REQ: on handshake, pc_req<=pc_f, pc_f<=pc_f+4 (32-bit wrap), go S_WAIT.
REQ-023 S_WAIT, rvalid & ~pc_src_e_i & ~stall_d_i & ~flush_d_i: IF/ID<={rdata,pc_req,pc_req+4,1}, go S_REQ.
REQ-024 S_WAIT, rvalid & stall_d_i & ~pc_src_e_i: rdata/pc_req captured in hold buffer, go S_HOLD.
REQ-025 S_WAIT, pc_src_e_i without rvalid: go S_DROP; with rvalid: discard data, go S_REQ.
REQ-026 S_DROP: on rvalid discard data, go S_REQ; no IF/ID update from dropped data.
REQ-027 S_HOLD: when ~stall_d_i, hold buffer loads IF/ID, go S_REQ; pc_src_e_i discards buffer, go S_REQ.
REQ-028 Any state, pc_src_e_i: pc_f<=pc_target_e_i with bits[1:0] forced 00; redirect has priority over +4.
REQ-029 IF/ID priority: flush_d_i > stall_d_i > delivery > bubble ({NOP_INSTR, valid 0}, PC fields hold).
REQ-030 Latency: request grant to IF/ID valid minimum 1 cycle after rvalid edge; back-to-back fetch 1 instr/2 cycles with zero-wait memory.
REQ-031 stall_f_i alone SHALL NOT drop an in-flight response.

Reset
REQ-032 On rst_i: state S_REQ, pc_f=RESET_PC, pc_req=RESET_PC, instr_d_o=NOP_INSTR, pc_d_o=0, pc_plus4_d_o=0, valid_d_o=0, fetch_misalign_o=0, hold buffer cleared.
REQ-033 Reset mid-S_WAIT: pending response after reset SHALL be ignored until first new grant (enter S_DROP if rvalid expected; memory also reset by rst_i, so S_REQ is sufficient).

Configuration
REQ-034 Macro FETCH_MISALIGN_CHECK_EN defined: fetch_misalign_o registered pulse one cycle after pc_src_e_i with pc_target_e_i[1:0]!=0.
REQ-035 Macro undefined: fetch_misalign_o tied 0; bits[1:0] still forced 00.

Structure
REQ-036 rv32_pkg holds fetch state encoding, NOP_INSTR constant, default RESET_PC.
REQ-037 One sub-module if_id_reg: IF/ID register with flush/stall/load priority of REQ-029.

Verification
REQ-038 Reset, zero-wait memory returning 32'h00500093: valid_d_o=1, pc_d_o=0, pc_plus4_d_o=4 after first response; next imem_addr_o=4.
REQ-039 pc_src_e_i with target 32'h0000_0100 during S_WAIT -> S_DROP, late rvalid data never appears, next imem_addr_o=32'h100.
REQ-040 stall_d_i=1 when rvalid arrives -> instr held in buffer, IF/ID unchanged; release -> buffered instr in IF/ID next cycle.
REQ-041 flush_d_i=1 with stall_d_i=1 -> instr_d_o=32'h00000013, valid_d_o=0.
REQ-042 pc_f=32'hFFFF_FFFC fetched -> pc_f wraps to 0, pc_plus4_d_o=0.
REQ-043 FETCH_MISALIGN_CHECK_EN, redirect to 32'h0000_0102 -> fetch_misalign_o one-cycle pulse, imem_addr_o=32'h100.
